// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle shift unit controller (SLL / SRL / SRA).
//
// A request (in_a, in_b, in_op) is accepted over a valid/ready handshake while
// idle. The result register is shifted one position per clock until the
// requested amount has been applied. The result is then presented on an
// output valid/ready handshake. Results match a combinational shifter,
// including shift amounts of WIDTH or more.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready high only when idle)
//   in_a, in_b, in_op   operand, shift amount, op (00 SLL, 01 SRL, 10 SRA, 11 illegal)
//   flush               abort the current operation and drop its result
//   out_valid/out_ready result handshake
//   out_res, out_err    result, and flag for a result produced from an illegal op
//   busy                high while shifting or holding a result
//
// Build option: define SHIFT_SEQ_FAST4_EN to shift 4 positions per clock
// while at least 4 positions remain. Results are identical either way.

module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpIll = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;

    logic             amt_oor;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] step1;

    // Any set bit above the counter range means the amount is >= WIDTH.
    assign amt_oor = |in_b[WIDTH-1:CNT_W];
    assign amt     = in_b[CNT_W-1:0];

    // Single-position shift of the working register. op_q only ever holds a
    // legal op while shifting.
    always_comb begin
        step1 = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
        unique case (op_q)
            OpSll:   step1 = {res_q[WIDTH-2:0], 1'b0};
            OpSrl:   step1 = {1'b0, res_q[WIDTH-1:1]};
            default: step1 = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
        endcase
    end

`ifdef SHIFT_SEQ_FAST4_EN
    logic [WIDTH-1:0] step4;

    always_comb begin
        step4 = {{4{res_q[WIDTH-1]}}, res_q[WIDTH-1:4]};
        unique case (op_q)
            OpSll:   step4 = {res_q[WIDTH-5:0], 4'b0000};
            OpSrl:   step4 = {4'b0000, res_q[WIDTH-1:4]};
            default: step4 = {{4{res_q[WIDTH-1]}}, res_q[WIDTH-1:4]};
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        op_d    = op_q;

        if (flush) begin
            // Flush wins over accept and completion; the result register keeps
            // whatever partial value it had, but it is never presented.
            state_d = StIdle;
            err_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d  = in_op;
                        res_d = in_a;
                        err_d = 1'b0;
                        cnt_d = '0;
                        if (in_op == OpIll) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else if (amt_oor) begin
                            res_d   = (in_op == OpSra) ? {WIDTH{in_a[WIDTH-1]}} : '0;
                            state_d = StDone;
                        end else if (amt == '0) begin
                            state_d = StDone;
                        end else begin
                            cnt_d   = amt;
                            state_d = StShift;
                        end
                    end
                end
                StShift: begin
                    // cnt_q is always >= 1 here, so the decrement cannot wrap.
`ifdef SHIFT_SEQ_FAST4_EN
                    if (cnt_q >= CNT_W'(4)) begin
                        res_d = step4;
                        cnt_d = cnt_q - CNT_W'(4);
                    end else begin
                        res_d = step1;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
`else
                    res_d = step1;
                    cnt_d = cnt_q - CNT_W'(1);
`endif
                    if (cnt_d == '0) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                        err_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OpSll;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_res   = res_q;
    assign out_err   = err_q;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle shift unit controller for the ALU.
- Accepts an operand, a shift amount and an op (SLL/SRL/SRA) over a valid/ready handshake.
- Sequences an internal 1-bit-per-cycle shift register to the final result and presents it on an output valid/ready handshake.
- Gives the ALU a low-area alternative to the combinational barrel shifter; results are bit-identical to the combinational shifters, including out-of-range amounts.

Parameters:
- WIDTH, 32, operand/result width; amount range check uses bits [WIDTH-1:5].
- CNT_W, 5, width of the internal remaining-shift counter (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  controller can accept a request (high only in IDLE)
- in_a  input  WIDTH  operand to shift
- in_b  input  WIDTH  shift amount
- in_op  input  2  00=SLL, 01=SRL, 10=SRA, 11=illegal
- flush  input  1  abort current operation, drop result
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_res  output  WIDTH  shift result
- out_err  output  1  result produced from illegal op
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (clk edge with rst=1), also mid-operation:
  - state=IDLE; in_ready=1; out_valid=0; out_res=0; out_err=0; busy=0; counter=0.
  - Any in-flight operation is discarded.
- States and transitions:
  - IDLE: in_ready=1. Request accepted on an edge with in_valid=1. Decision at accept:
    - in_op=11: out_res<=in_a, out_err<=1, next DONE.
    - |in_b[WIDTH-1:5]=1 (out of range): out_res<=(SRA ? {WIDTH{in_a[WIDTH-1]}} : 0), out_err<=0, next DONE.
    - in_b[4:0]=0: out_res<=in_a, next DONE.
    - Otherwise: out_res<=in_a, counter<=in_b[4:0], next SHIFT.
  - SHIFT: each edge shifts out_res by 1 and decrements counter.
    - SLL: zero fill at LSB.
    - SRL: zero fill at MSB.
    - SRA: fill MSB with current out_res[WIDTH-1].
    - When counter==1 at the edge, next state is DONE.
  - DONE: out_valid=1; out_res and out_err held stable while out_ready=0. Edge with out_ready=1 returns to IDLE, clears out_valid and out_err; out_res retains its last value.
- Latency (accept edge to first cycle out_valid=1):
  - In-range amount n: n+1 edges (n=0 gives 1).
  - Out-of-range amount or illegal op: 1 edge.
- Handshake rules:
  - in_valid is ignored outside IDLE; no overlap or pipelining, so throughput is one request per (latency+1) cycles minimum.
  - in_ready is registered from state.
  - out_valid never drops without out_ready, except on rst or flush.
- flush:
  - Any state returns to IDLE next edge, out_valid=0, out_err=0, counter=0.
  - flush has priority over accept and completion.
  - rst has priority over flush.
- busy = (state != IDLE).
- The counter never wraps: decrement happens only in SHIFT with counter>=1.

Optional Feature:
- Macro: SHIFT_SEQ_FAST4_EN.
- Defined: in SHIFT, when counter>=4 the shift is 4 positions per edge and counter decrements by 4; otherwise shift by 1. Latency is floor(n/4)+(n mod 4)+1 edges.
- Not defined: strictly 1 position per edge as above.
- Results are identical in both builds.

Test Plan:
- Reset mid-shift: SRA a=0x80000000, b=20; assert rst after 5 cycles -> next cycle in_ready=1, out_valid=0, out_res=0, busy=0.
- SRA a=0x80000010, b=4 -> out_valid after 5 edges, out_res=0xF8000001, out_err=0; hold out_ready=0 for 3 cycles -> out_res stable, in_valid pulses ignored.
- SLL a=0x00000001, b=31 -> out_res=0x80000000 after 32 edges; b=0 -> out_res=0x00000001 after 1 edge.
- Out of range: SRA a=0xF0000000, b=0x00000020 -> out_res=0xFFFFFFFF after 1 edge; SRL same operands -> 0x00000000; SLL a=0x1, b=0x100 -> 0x00000000.
- Illegal op 11, a=0x12345678 -> out_res=0x12345678, out_err=1 after 1 edge; out_err cleared after out_ready handshake.
- Flush during SHIFT (SRL a=0xFFFFFFFF, b=16, flush on cycle 3) -> IDLE next edge, no out_valid. Back-to-back request then completes SRL b=16 -> 0x0000FFFF. With SHIFT_SEQ_FAST4_EN, b=16 has latency 5 edges.
